nibble_io_port: RTL
===================

Name: nibble_io_port

Overview:
- Byte-wide I/O peripheral that sits on the far side of the processor's 4-bit output register and input pins.
- TX path: assembles the nibble pairs the processor writes into o_reg into bytes, then delivers them to a downstream consumer over a valid/ready handshake.
- RX path: accepts bytes from an upstream producer and presents them to the processor on i_pins, one nibble at a time.
- Status outputs (tx_full, rx_avail, err) feed the sequencer's conditional-jump flags.

Parameters:
- DEPTH, 2, byte entries per FIFO (TX and RX each); power of 2, at least 2.
- AW, 1, FIFO pointer width, equal to log2(DEPTH).

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- o_reg  in  4  processor output register value.
- o_we  in  1  one-cycle pulse, same cycle o_reg is loaded (processor reg_en[8]).
- i_rd  in  1  one-cycle pulse when processor consumes i_pins (source_sel==9 with register write).
- clr_err  in  1  clears sticky error flags.
- i_pins  out  4  nibble presented to processor.
- rx_avail  out  1  RX FIFO non-empty.
- tx_full  out  1  TX FIFO full.
- err  out  2  sticky flags: [0] TX overflow, [1] RX underflow.
- tx_data  out  8  head byte of TX FIFO.
- tx_valid  out  1  TX FIFO non-empty.
- tx_ready  in  1  downstream accepts tx_data.
- rx_data  in  8  upstream byte.
- rx_valid  in  1  upstream byte valid.
- rx_ready  out  1  RX FIFO not full.

Behaviour:
- Reset (reset_n low, asynchronous): both FIFOs empty, pointers 0, tx_phase=0, rx_phase=0, nibble holding register 0, err=0.
  - Resulting outputs: tx_valid=0, tx_data=0, rx_avail=0, rx_ready=1, tx_full=0, i_pins=0.
  - Reset asserted mid-byte discards any half-assembled nibble and all FIFO contents.
- TX assembly:
  - o_we with tx_phase=0: o_reg goes into the low-nibble holding register; tx_phase becomes 1.
  - o_we with tx_phase=1: the byte {o_reg, low} is pushed; tx_phase becomes 0.
  - The push and the phase toggle occur even when the FIFO is full.
  - Full case: if the FIFO is full at the push edge and no pop occurs in that cycle, the byte is dropped and err[0] is set.
  - Full case with a pop in the same cycle (tx_valid&tx_ready): the push succeeds.
- TX handshake:
  - A transfer occurs on any edge where tx_valid&tx_ready.
  - tx_data and tx_valid are registered state: a byte pushed into an empty FIFO at edge N is visible at N+1.
  - tx_data must hold stable while tx_valid=1 and tx_ready=0.
  - tx_data=0 when the FIFO is empty.
- RX handshake:
  - Push on any edge where rx_valid&rx_ready.
  - rx_ready = !full, combinational from registered count; no push is possible when full.
  - Push and pop in the same cycle: both happen, count unchanged.
- RX presentation:
  - i_pins is combinational from registered state: head[3:0] when rx_phase=0, head[7:4] when rx_phase=1, 0 when the FIFO is empty.
  - i_rd with non-empty and rx_phase=0: rx_phase becomes 1.
  - i_rd with non-empty and rx_phase=1: pop, rx_phase becomes 0.
  - i_rd when empty: ignored, err[1] set.
  - A byte pushed into an empty FIFO at edge N appears on i_pins at N+1.
- Pointer and count rules:
  - Pointers wrap modulo DEPTH.
  - count ranges 0..DEPTH and is AW+1 bits wide.
  - full = (count==DEPTH); empty = (count==0).
- err handling:
  - Flags are sticky.
  - clr_err clears both flags at the next edge.
  - If clr_err coincides with a new error event, the flag is set (set wins).
- o_we and i_rd are independent; both may be asserted in the same cycle.

Test Plan:
- Reset, then o_we with o_reg=4'h5, then o_we with o_reg=4'hA, tx_ready=1 -> tx_valid=1 with tx_data=8'hA5 exactly one cycle after the second o_we; tx_valid=0 on the next cycle.
- tx_ready=0, write 3 bytes (0x11, 0x22, 0x33) -> tx_full=1 after the second; 0x33 dropped, err=2'b01. Release tx_ready -> 0x11 then 0x22 delivered, in order.
- rx_data=8'hC3 with rx_valid=1 for one cycle -> next cycle i_pins=4'h3 and rx_avail=1; after i_rd, i_pins=4'hC; after a second i_rd, rx_avail=0 and i_pins=0.
- Hold rx_valid=1 with bytes 0x01, 0x02, 0x03 -> rx_ready=0 after two pushes; 0x03 held upstream. Two i_rd pulses pop 0x01, then rx_ready=1 and 0x03 is accepted.
- i_rd with RX empty -> err[1]=1. Pulse clr_err -> err=0 next cycle. Pulse clr_err together with a new empty i_rd -> err[1] stays 1.
- Assert reset_n low asynchronously between the two nibble writes, then write 4'h7 and 4'h8 -> tx_data=8'h87; no stale nibble from before reset.

Source files
------------

// File: rtl/nibble_io_port.sv
// rtl/nibble_io_port.sv - nibble-to-byte TX/RX bridge between a 4-bit processor port and byte streams
//
// nibble_fifo: byte FIFO with registered head, rdata forced to 0 while empty.
//   clk, reset_n          clock, async active-low reset
//   push, wdata           write strobe and byte (caller guarantees room or a same-cycle pop)
//   pop                   read strobe (caller guarantees non-empty)
//   rdata, full, empty    head byte and occupancy flags
//
// nibble_io_port: top level.
//   o_reg, o_we           processor output nibble and its load pulse (low nibble first)
//   i_rd, i_pins          processor consume pulse and presented nibble (low nibble first)
//   clr_err, err          sticky error flags [0] TX overflow, [1] RX underflow, and their clear
//   tx_full, rx_avail     status flags for the sequencer
//   tx_data/valid/ready   downstream byte stream
//   rx_data/valid/ready   upstream byte stream

module nibble_fifo #(
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty
);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    // Storage needs no reset: the head is masked to 0 while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);
    assign rdata = empty ? 8'h00 : mem[rd_ptr];
endmodule

module nibble_io_port #(
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] o_reg,
    input  logic       o_we,
    input  logic       i_rd,
    input  logic       clr_err,
    output logic [3:0] i_pins,
    output logic       rx_avail,
    output logic       tx_full,
    output logic [1:0] err,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready
);
    logic       tx_phase;
    logic [3:0] tx_low;
    logic       tx_empty;
    logic       tx_push_req;
    logic       tx_push;
    logic       tx_pop;
    logic       tx_ovf;

    logic       rx_phase;
    logic [7:0] rx_head;
    logic       rx_full;
    logic       rx_empty;
    logic       rx_push;
    logic       rx_pop;
    logic       rx_unf;

    // A second nibble always completes a byte; a full FIFO can still take it
    // when the head leaves in the same cycle, otherwise the byte is lost.
    assign tx_push_req = o_we & tx_phase;
    assign tx_pop      = tx_valid & tx_ready;
    assign tx_push     = tx_push_req & (~tx_full | tx_pop);
    assign tx_ovf      = tx_push_req & tx_full & ~tx_pop;
    assign tx_valid    = ~tx_empty;

    assign rx_ready    = ~rx_full;
    assign rx_avail    = ~rx_empty;
    assign rx_push     = rx_valid & rx_ready;
    assign rx_pop      = i_rd & rx_avail & rx_phase;
    assign rx_unf      = i_rd & rx_empty;

    // rx_head is 0 when empty, so i_pins needs no separate empty masking.
    assign i_pins      = rx_phase ? rx_head[7:4] : rx_head[3:0];

    nibble_fifo #(.DEPTH(DEPTH), .AW(AW)) u_tx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (tx_push),
        .wdata   ({o_reg, tx_low}),
        .pop     (tx_pop),
        .rdata   (tx_data),
        .full    (tx_full),
        .empty   (tx_empty)
    );

    nibble_fifo #(.DEPTH(DEPTH), .AW(AW)) u_rx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (rx_push),
        .wdata   (rx_data),
        .pop     (rx_pop),
        .rdata   (rx_head),
        .full    (rx_full),
        .empty   (rx_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_phase <= 1'b0;
            tx_low   <= 4'h0;
            rx_phase <= 1'b0;
            err      <= 2'b00;
        end else begin
            if (o_we) begin
                tx_phase <= ~tx_phase;
                if (!tx_phase) begin
                    tx_low <= o_reg;
                end
            end
            if (i_rd && rx_avail) begin
                rx_phase <= ~rx_phase;
            end
            // New error events win over a simultaneous clear.
            err[0] <= tx_ovf | (err[0] & ~clr_err);
            err[1] <= rx_unf | (err[1] & ~clr_err);
        end
    end
endmodule
